// File: rtl/ball_ctl_if.sv
// Ball controller game bus: paddle/collision in,
// ball position and game status out.
interface ball_ctl_if;
  logic [11:0] paddle_x;
  logic        collision_det;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic [1:0]  lives;
  logic        ball_active;
  logic        game_over;

  modport master (
    input  paddle_x,
    input  collision_det,
    output x_pos,
    output y_pos,
    output lives,
    output ball_active,
    output game_over
  );

  modport slave (
    output paddle_x,
    output collision_det,
    input  x_pos,
    input  y_pos,
    input  lives,
    input  ball_active,
    input  game_over
  );
endinterface

// File: rtl/ball_ctl.sv
// Ball motion controller: per-frame motion with wall,
// paddle and block bounces, plus launch/lives game flow.
module ball_ctl #(
  parameter int SCREEN_W  = 1024,
  parameter int SCREEN_H  = 768,
  parameter int BALL_SIZE = 16,
  parameter int PADDLE_W  = 128,
  parameter int PADDLE_Y  = 700,
  parameter int SPEED     = 4,
  parameter int LIVES     = 3
) (
  input  logic pclk,
  input  logic reset,
  input  logic vsync_in,
  input  logic mouse_left,
  ball_ctl_if.master bus
);

  localparam logic signed [12:0] X_MAX  =
    13'(SCREEN_W - BALL_SIZE);
  localparam logic signed [12:0] Y_REST =
    13'(PADDLE_Y - BALL_SIZE);
  localparam logic signed [12:0] Y_BOT  =
    13'(SCREEN_H - BALL_SIZE);
  localparam logic signed [12:0] V_POS  = 13'(SPEED);
  localparam logic signed [12:0] V_NEG  = 13'(-SPEED);

  localparam logic [11:0] X_MAX12 =
    12'(SCREEN_W - BALL_SIZE);
  localparam logic [11:0] Y_REST12 =
    12'(PADDLE_Y - BALL_SIZE);
  localparam logic [11:0] X_HOME =
    12'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [11:0] X_OFS =
    12'(PADDLE_W / 2 - BALL_SIZE / 2);

  localparam logic [12:0] U_BSZ  = 13'(BALL_SIZE);
  localparam logic [12:0] U_BHF  = 13'(BALL_SIZE / 2);
  localparam logic [12:0] U_PW   = 13'(PADDLE_W);
  localparam logic [12:0] U_PHF  = 13'(PADDLE_W / 2);
  localparam logic [12:0] U_PY   = 13'(PADDLE_Y);

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    LOST,
    OVER
  } state_t;

  state_t state_q, state_d;

  logic vs_d;
  logic tick;
  logic ms1, ms2, ms_d;
  logic launch_rise;
  logic launch_q;
  logic launch_now;
  logic hit_q;
  logic hit_now;

  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic signed [12:0] vx_q, vx_d;
  logic signed [12:0] vy_q, vy_d;
  logic [1:0] lives_q, lives_d;

  logic [12:0] ux, uy, upx;
  logic signed [12:0] nx, ny;
  logic pad_hit;
  logic pad_left;

  assign tick        = vsync_in & ~vs_d;
  assign launch_rise = ms2 & ~ms_d;
  assign launch_now  = launch_q | launch_rise;
  assign hit_now     = hit_q | bus.collision_det;

  // vsync edge register and mouse synchroniser chain
  always_ff @(posedge pclk) begin
    if (reset) begin
      vs_d <= 1'b0;
      ms1  <= 1'b0;
      ms2  <= 1'b0;
      ms_d <= 1'b0;
    end else begin
      vs_d <= vsync_in;
      ms1  <= mouse_left;
      ms2  <= ms1;
      ms_d <= ms2;
    end
  end

  // launch and block-hit latches, consumed at each frame tick
  always_ff @(posedge pclk) begin
    if (reset) begin
      launch_q <= 1'b0;
      hit_q    <= 1'b0;
    end else if (tick) begin
      launch_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      if (launch_rise) launch_q <= 1'b1;
      if (bus.collision_det) hit_q <= 1'b1;
    end
  end

  assign ux  = {1'b0, x_q};
  assign uy  = {1'b0, y_q};
  assign upx = {1'b0, bus.paddle_x};
  assign nx  = $signed(ux) + vx_q;
  assign ny  = $signed(uy) + vy_q;

  assign pad_hit = (vy_q > 13'sd0)
                && ((uy + U_BSZ) <= U_PY)
                && (ny >= Y_REST)
                && ((ux + U_BSZ) > upx)
                && (ux < (upx + U_PW));

  assign pad_left = (ux + U_BHF) < (upx + U_PHF);

  // state register
  always_ff @(posedge pclk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state, position, velocity and lives
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    lives_d = lives_q;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          if (launch_now) begin
            vx_d    = V_POS;
            vy_d    = V_NEG;
            state_d = MOVE;
          end else begin
            x_d = bus.paddle_x + X_OFS;
            y_d = Y_REST12;
          end
        end
      end
      MOVE: begin
        if (tick) begin
          if (nx <= 13'sd0) begin
            x_d  = 12'd0;
            vx_d = V_POS;
          end else if (nx >= X_MAX) begin
            x_d  = X_MAX12;
            vx_d = V_NEG;
          end else begin
            x_d = nx[11:0];
          end
          if (ny <= 13'sd0) begin
            y_d  = 12'd0;
            vy_d = V_POS;
          end else if (hit_now) begin
            y_d  = ny[11:0];
            vy_d = -vy_q;
          end else if (pad_hit) begin
            y_d  = Y_REST12;
            vy_d = V_NEG;
            vx_d = pad_left ? V_NEG : V_POS;
          end else if (ny >= Y_BOT) begin
            state_d = LOST;
          end else begin
            y_d = ny[11:0];
          end
        end
      end
      LOST: begin
        if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
        if (lives_q <= 2'd1) state_d = OVER;
        else                 state_d = IDLE;
      end
      OVER: begin
        if (tick && launch_now) begin
          lives_d = LIVES_INIT;
          state_d = IDLE;
        end
      end
    endcase
  end

  // position, velocity and lives registers
  always_ff @(posedge pclk) begin
    if (reset) begin
      x_q     <= X_HOME;
      y_q     <= Y_REST12;
      vx_q    <= V_POS;
      vy_q    <= V_NEG;
      lives_q <= LIVES_INIT;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      lives_q <= lives_d;
    end
  end

  assign bus.x_pos       = x_q;
  assign bus.y_pos       = y_q;
  assign bus.lives       = lives_q;
  assign bus.ball_active = (state_q == MOVE);
  assign bus.game_over   = (state_q == OVER);

endmodule
